// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered display load.
// Define SSEG_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 is always shown).
module sseg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_valid,
    input  logic [4*N_DIGITS-1:0] load_value,
    input  logic [N_DIGITS-1:0]   load_dp,
    output logic                  load_ready,
    output logic [3:0]            bcd,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]    CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [0:0]            state_q, state_d;
    logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  ready_q, ready_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_q, frame_d;

    logic                  slot_end, frame_end, xfer;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  digit_dark;

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = en && slot_end && (idx_q == IDX_LAST);
        xfer      = load_valid && ready_q;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (en) begin
            if (slot_end) begin
                cnt_d   = '0;
                state_d = ST_BLANK;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_SHOW) begin
                    state_d = ST_SHOW;
                end
            end
        end
    end

    // Pending is only promoted at the frame boundary, so a frame never mixes two values.
    always_comb begin
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        ready_d    = ready_q;
        if (frame_end && !ready_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            ready_d   = 1'b1;
        end else if (xfer) begin
            pend_val_d = load_value;
            pend_dp_d  = load_dp;
            ready_d    = 1'b0;
        end
    end

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        digit_dark = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = act_val_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
            end
        end
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic zero_above;
            zero_above = 1'b1;
            // Walk down from the top digit; a digit is dark while everything above it is blank too.
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above && (act_val_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
                if (idx_q == IDX_W'(i)) begin
                    digit_dark = zero_above;
                end
            end
        end
`endif
    end

    always_comb begin
        an_d    = '1;
        bcd_d   = bcd_q;
        dp_n_d  = 1'b1;
        frame_d = frame_end;
        if (en && state_q == ST_SHOW) begin
            bcd_d  = cur_nib;
            dp_n_d = ~cur_dp;
            if (!digit_dark) begin
                an_d = ~(AN_ONE << idx_q);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the display buffers are reset too,
    // because a cleared display after reset is a visible requirement, not just a convenience.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= ST_BLANK;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            ready_q    <= 1'b1;
            an_q       <= '1;
            bcd_q      <= '0;
            dp_n_q     <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            ready_q    <= ready_d;
            an_q       <= an_d;
            bcd_q      <= bcd_d;
            dp_n_q     <= dp_n_d;
            frame_q    <= frame_d;
        end
    end

    assign load_ready = ready_q;
    assign bcd        = bcd_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl with N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Honours SSEG_LEADING_ZERO_BLANK_EN when building expectations.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic        load_ready;
    logic [3:0]  bcd;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pos      = 0;     // linear scan position (idx*8+cnt) the next enabled edge will use
    logic [3:0]  exp_bcd  = 4'h0;

    sseg_scan_ctrl #(
        .N_DIGITS    (4),
        .PRESCALE    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load_valid(load_valid),
        .load_value(load_value),
        .load_dp   (load_dp),
        .load_ready(load_ready),
        .bcd       (bcd),
        .dp_n      (dp_n),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // One clock, then check every display output against the schedule for the position just used.
    task automatic tick_check(input logic [15:0] val, input logic [3:0] dp);
        int         sp;
        int         slot;
        int         dig;
        logic       en_s;
        logic       show;
        logic       dark;
        logic [3:0] an_e;
        logic       dpn_e;
        logic       fd_e;
        sp   = pos;
        en_s = en;
        @(posedge clk);
        @(negedge clk);
        if (en_s) pos++;
        slot = sp % 8;
        dig  = (sp / 8) % 4;
        show = en_s && (slot >= 2);
        dark = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (dig > 0) begin
            dark = 1'b1;
            for (int j = dig; j < 4; j++) begin
                if (val[4*j +: 4] != 4'h0 || dp[j]) dark = 1'b0;
            end
        end
`endif
        an_e  = 4'b1111;
        dpn_e = 1'b1;
        if (show) begin
            exp_bcd = val[4*dig +: 4];
            dpn_e   = ~dp[dig];
            if (!dark) an_e = ~(4'b0001 << dig);
        end
        fd_e = en_s && ((sp % 32) == 31);
        n_checks += 4;
        if (an !== an_e) begin
            n_fail++;
            $display("FAIL an pos=%0d got %b exp %b", sp, an, an_e);
        end
        if (bcd !== exp_bcd) begin
            n_fail++;
            $display("FAIL bcd pos=%0d got %h exp %h", sp, bcd, exp_bcd);
        end
        if (dp_n !== dpn_e) begin
            n_fail++;
            $display("FAIL dp_n pos=%0d got %b exp %b", sp, dp_n, dpn_e);
        end
        if (frame_done !== fd_e) begin
            n_fail++;
            $display("FAIL frame_done pos=%0d got %b exp %b", sp, frame_done, fd_e);
        end
    endtask

    task automatic check_ready(input logic exp, input string tag);
        n_checks++;
        if (load_ready !== exp) begin
            n_fail++;
            $display("FAIL load_ready %s pos=%0d got %b exp %b", tag, pos, load_ready, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks += 5;
        if (an !== 4'b1111) begin
            n_fail++; $display("FAIL %s an got %b exp 1111", tag, an);
        end
        if (bcd !== 4'h0) begin
            n_fail++; $display("FAIL %s bcd got %h exp 0", tag, bcd);
        end
        if (dp_n !== 1'b1) begin
            n_fail++; $display("FAIL %s dp_n got %b exp 1", tag, dp_n);
        end
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL %s frame_done got %b exp 0", tag, frame_done);
        end
        if (load_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s load_ready got %b exp 1", tag, load_ready);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        en         = 1'b1;
        load_valid = 1'b0;
        load_value = 16'h0;
        load_dp    = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst     = 1'b0;
        pos     = 0;
        exp_bcd = 4'h0;
    endtask

    // Two full frames of the idle value: blank/show timing, digit order, frame_done period.
    task automatic test_scan;
        repeat (64) tick_check(16'h0000, 4'h0);
        check_ready(1'b1, "idle");
    endtask

    task automatic test_load;
        while (pos < 74) tick_check(16'h0000, 4'h0);
        load_valid = 1'b1;
        load_value = 16'h1A3F;
        load_dp    = 4'b0100;
        tick_check(16'h0000, 4'h0);
        load_valid = 1'b0;
        check_ready(1'b0, "after_load");
        while (pos < 95) begin
            tick_check(16'h0000, 4'h0);
            check_ready(1'b0, "pending_full");
        end
        tick_check(16'h0000, 4'h0);
        check_ready(1'b1, "after_swap");
        repeat (32) tick_check(16'h1A3F, 4'b0100);
    endtask

    task automatic test_back_to_back;
        while (pos < 133) tick_check(16'h1A3F, 4'b0100);
        load_valid = 1'b1;
        load_value = 16'h1234;
        load_dp    = 4'b0001;
        tick_check(16'h1A3F, 4'b0100);
        load_value = 16'h5678;
        load_dp    = 4'b1000;
        check_ready(1'b0, "b2b_first");
        while (pos < 159) begin
            tick_check(16'h1A3F, 4'b0100);
            check_ready(1'b0, "b2b_blocked");
        end
        tick_check(16'h1A3F, 4'b0100);
        check_ready(1'b1, "b2b_swap");
        tick_check(16'h1234, 4'b0001);
        load_valid = 1'b0;
        check_ready(1'b0, "b2b_second");
        while (pos < 191) tick_check(16'h1234, 4'b0001);
        tick_check(16'h1234, 4'b0001);
        check_ready(1'b1, "b2b_swap2");
        repeat (32) tick_check(16'h5678, 4'b1000);
    endtask

    task automatic test_enable;
        while (pos < 235) tick_check(16'h5678, 4'b1000);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                check_ready(1'b1, "en_off_before");
                load_valid = 1'b1;
                load_value = 16'h0070;
                load_dp    = 4'h0;
            end
            tick_check(16'h5678, 4'b1000);
            if (i == 3) begin
                load_valid = 1'b0;
                check_ready(1'b0, "en_off_load");
            end
        end
        n_checks++;
        if (pos !== 235) begin
            n_fail++;
            $display("FAIL en_freeze pos got %0d exp 235", pos);
        end
        en = 1'b1;
        while (pos < 256) tick_check(16'h5678, 4'b1000);
    endtask

    // Frame showing 0x0070: leading digits dark only when the blanking build is selected.
    task automatic test_lzb;
        int lit;
        lit = 0;
        repeat (32) begin
            tick_check(16'h0070, 4'h0);
            if (an !== 4'b1111) lit++;
        end
        n_checks++;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (lit !== 12) begin
            n_fail++; $display("FAIL lzb lit_cycles got %0d exp 12", lit);
        end
`else
        if (lit !== 24) begin
            n_fail++; $display("FAIL lzb lit_cycles got %0d exp 24", lit);
        end
`endif
    endtask

    task automatic test_reset_mid;
        while (pos < 290) tick_check(16'h0070, 4'h0);
        load_valid = 1'b1;
        load_value = 16'h9999;
        load_dp    = 4'hF;
        tick_check(16'h0070, 4'h0);
        load_valid = 1'b0;
        check_ready(1'b0, "mid_pending");
        while (pos < 308) tick_check(16'h0070, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst     = 1'b0;
        pos     = 0;
        exp_bcd = 4'h0;
        repeat (40) tick_check(16'h0000, 4'h0);
        check_ready(1'b1, "after_reset_mid");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_enable();
        test_lzb();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
